// File: rtl/featuremap_channel_accum.sv
// Channel-reduction stage: sums NUM_CHANNELS FP32 partial results plus a bias
// through one time-multiplexed adder, with optional ReLU and frame-end marking.
module featuremap_channel_accum #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          NUM_CHANNELS = 8,
    parameter logic [31:0] BIAS         = 32'h3AF95B63,
    parameter int          RELU         = 0,
    parameter int          PIXELS       = 3136
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data_in,
    input  logic                               valid_in,
    output logic                               ready_in,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               valid_out,
    input  logic                               ready_out,
    output logic                               last_out
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    // FP32 add, round toward zero; denormals read as zero, underflow flushes to +0.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]        ea, eb, e_big, shamt;
        logic [23:0]       ma, mb;
        logic [27:0]       big_x, small_x, mask, aligned, sum, norm;
        logic              sign_big, a_big, found;
        logic [4:0]        lz;
        logic signed [9:0] e_res;
        logic [22:0]       frac;
        norm  = 28'd0;
        frac  = 23'd0;
        e_res = 10'sd0;
        ea = a[30:23];
        eb = b[30:23];
        ma = (ea != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
        mb = (eb != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
        a_big    = {ea, ma} >= {eb, mb};
        big_x    = a_big ? {1'b0, ma, 3'b000} : {1'b0, mb, 3'b000};
        small_x  = a_big ? {1'b0, mb, 3'b000} : {1'b0, ma, 3'b000};
        e_big    = a_big ? ea : eb;
        shamt    = a_big ? (ea - eb) : (eb - ea);
        sign_big = a_big ? a[31] : b[31];
        // Low three bits act as guard/round/sticky; everything shifted out folds into bit 0.
        if (shamt >= 8'd28) begin
            mask    = '1;
            aligned = 28'd0;
        end else begin
            mask    = (28'd1 << shamt) - 28'd1;
            aligned = small_x >> shamt;
        end
        aligned[0] = aligned[0] | (|(small_x & mask));
        sum = (a[31] ^ b[31]) ? (big_x - aligned) : (big_x + aligned);
        found = 1'b0;
        lz    = 5'd0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                found = 1'b1;
                lz    = 5'(26 - i);
            end
        end
        if (sum[27]) begin
            frac  = sum[26:4];
            e_res = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            norm  = sum << lz;
            frac  = norm[25:3];
            e_res = $signed({2'b00, e_big}) - $signed({5'd0, lz});
        end
        if (sum == 28'd0 || e_res <= 10'sd0) begin
            return 32'd0;
        end else if (e_res >= 10'sd255) begin
            return {sign_big, 8'hFF, 23'd0};
        end
        return {sign_big, e_res[7:0], frac};
    endfunction

    logic [1:0]                         state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [PIX_W-1:0]                   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]              acc_q, acc_d;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] chan_q, chan_d;
    logic [DATA_WIDTH-1:0]              data_out_q, data_out_d;
    logic                               last_q, last_d;
    logic                               ready_q, ready_d;
    logic [DATA_WIDTH-1:0]              ch_w [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]              sum_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_unpack
            assign ch_w[gi] = chan_q[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign sum_w = fp_add(acc_q, ch_w[idx_q]);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        chan_d     = chan_q;
        data_out_d = data_out_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in && ready_q) begin
                    chan_d  = data_in;
                    acc_d   = BIAS;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = sum_w;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    data_out_d = ((RELU != 0) && sum_w[31]) ? '0 : sum_w;
                    last_d     = (cnt_q == LAST_PIX);
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (ready_out) begin
                    cnt_d   = (cnt_q == LAST_PIX) ? '0 : cnt_q + PIX_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            chan_q     <= '0;
            data_out_q <= '0;
            last_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            chan_q     <= chan_d;
            data_out_q <= data_out_d;
            last_q     <= last_d;
            ready_q    <= ready_d;
        end
    end

    assign ready_in  = ready_q;
    assign valid_out = (state_q == S_OUT);
    assign data_out  = data_out_q;
    assign last_out  = last_q;

endmodule

// File: tb/tb_featuremap_channel_accum.sv
// Directed bench: two instances (RELU off / PIXELS=4 and RELU on / PIXELS=1) driven in lockstep.
module tb_featuremap_channel_accum;

    logic         clk;
    logic         rst;
    logic [255:0] data_in;
    logic         valid_in;
    logic         ready_out;
    logic         ready_a, valid_a, last_a;
    logic [31:0]  data_a;
    logic         ready_r, valid_r, last_r;
    logic [31:0]  data_r;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    featuremap_channel_accum #(
        .DATA_WIDTH(32), .NUM_CHANNELS(8), .BIAS(32'h3F000000), .RELU(0), .PIXELS(4)
    ) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_a),
        .data_out(data_a), .valid_out(valid_a), .ready_out(ready_out), .last_out(last_a)
    );

    featuremap_channel_accum #(
        .DATA_WIDTH(32), .NUM_CHANNELS(8), .BIAS(32'h3F000000), .RELU(1), .PIXELS(1)
    ) dut_r (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_r),
        .data_out(data_r), .valid_out(valid_r), .ready_out(ready_out), .last_out(last_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] pack8(input logic [31:0] c0, c1, c2, c3, c4, c5, c6, c7);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Offers one pixel, waits for its result and completes the output handshake.
    task automatic run_pixel(input logic [255:0] d, output logic [31:0] oa, output logic [31:0] orr,
                             output logic la, output logic lr, output logic vr, output int lat);
        int w;
        w = 0;
        data_in = d;
        valid_in = 1'b1;
        while (!ready_a && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_a && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        oa = data_a; orr = data_r; la = last_a; lr = last_r; vr = valid_r;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (ready_a !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ready_a); end
        vectors++; if (valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        vectors++; if (data_a !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 00000000", data_a); end
        vectors++; if (last_a !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", last_a); end
        rst = 1'b0;
        vectors++; if (ready_a !== 1'b0) begin miscompares++; $display("FAIL reset_ready_deassert: got %b want 0", ready_a); end
        @(posedge clk); #1;
        vectors++; if (ready_a !== 1'b1) begin miscompares++; $display("FAIL reset_ready_rise: got %b want 1", ready_a); end
    endtask

    task automatic test_basic();
        logic [31:0] oa, orr; logic la, lr, vr; int lat;
        run_pixel({8{32'h3F800000}}, oa, orr, la, lr, vr, lat);
        vectors++; if (oa !== 32'h41080000) begin miscompares++; $display("FAIL basic_sum: got %h want 41080000", oa); end
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL basic_latency: got %0d want 9", lat); end
        vectors++; if (vr !== 1'b1) begin miscompares++; $display("FAIL basic_relu_valid: got %b want 1", vr); end
        vectors++; if (orr !== 32'h41080000) begin miscompares++; $display("FAIL basic_relu_sum: got %h want 41080000", orr); end
        run_pixel(pack8(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000), oa, orr, la, lr, vr, lat);
        vectors++; if (oa !== 32'h42120000) begin miscompares++; $display("FAIL mixed_sum: got %h want 42120000", oa); end
    endtask

    task automatic test_relu();
        logic [31:0] oa, orr; logic la, lr, vr; int lat;
        run_pixel({8{32'hBF800000}}, oa, orr, la, lr, vr, lat);
        vectors++; if (oa !== 32'hC0F00000) begin miscompares++; $display("FAIL relu_off: got %h want c0f00000", oa); end
        vectors++; if (orr !== 32'h00000000) begin miscompares++; $display("FAIL relu_on: got %h want 00000000", orr); end
    endtask

    task automatic test_cancel_order();
        logic [31:0] oa, orr; logic la, lr, vr; int lat;
        run_pixel(pack8(32'h40400000, 32'hC0400000, 32'hBF000000, 0, 0, 0, 0, 0), oa, orr, la, lr, vr, lat);
        vectors++; if (oa !== 32'h00000000) begin miscompares++; $display("FAIL cancel_exact: got %h want 00000000", oa); end
        // 0.5 is absorbed by 2^24 before the cancelling term arrives.
        run_pixel(pack8(32'h4B800000, 32'hCB800000, 0, 0, 0, 0, 0, 0), oa, orr, la, lr, vr, lat);
        vectors++; if (oa !== 32'h00000000) begin miscompares++; $display("FAIL add_order: got %h want 00000000", oa); end
    endtask

    task automatic test_arith_edges();
        logic [255:0] vin [7];
        logic [31:0]  exp_a [7];
        logic [31:0]  exp_r [7];
        logic [31:0]  oa, orr; logic la, lr, vr; int lat;
        vin[0] = pack8(32'h3F800000, 32'h33C00000, 0, 0, 0, 0, 0, 0); exp_a[0] = 32'h3FC00000; exp_r[0] = 32'h3FC00000;
        vin[1] = pack8(32'h3F800000, 32'hB0800000, 0, 0, 0, 0, 0, 0); exp_a[1] = 32'h3FBFFFFF; exp_r[1] = 32'h3FBFFFFF;
        vin[2] = pack8(0, 0, 0, 0, 0, 0, 32'h7F7FFFFF, 32'h7F7FFFFF); exp_a[2] = 32'h7F800000; exp_r[2] = 32'h7F800000;
        vin[3] = pack8(0, 0, 0, 0, 0, 0, 32'hFF7FFFFF, 32'hFF7FFFFF); exp_a[3] = 32'hFF800000; exp_r[3] = 32'h00000000;
        vin[4] = pack8(32'hBF000000, 32'h00400000, 0, 0, 0, 0, 0, 0); exp_a[4] = 32'h00000000; exp_r[4] = 32'h00000000;
        vin[5] = pack8(32'hBF000000, 32'h00C00000, 32'h80800000, 0, 0, 0, 0, 0); exp_a[5] = 32'h00000000; exp_r[5] = 32'h00000000;
        vin[6] = pack8(0, 0, 0, 0, 0, 0, 32'h7F7FFFFF, 0); exp_a[6] = 32'h7F7FFFFF; exp_r[6] = 32'h7F7FFFFF;
        for (int k = 0; k < 7; k++) begin
            run_pixel(vin[k], oa, orr, la, lr, vr, lat);
            vectors++; if (oa !== exp_a[k]) begin miscompares++; $display("FAIL edge%0d_sum: got %h want %h", k, oa, exp_a[k]); end
            vectors++; if (orr !== exp_r[k]) begin miscompares++; $display("FAIL edge%0d_relu: got %h want %h", k, orr, exp_r[k]); end
        end
    endtask

    task automatic test_backpressure();
        int w; int lat;
        do_reset();
        ready_out = 1'b0;
        data_in = {8{32'h3F800000}};
        valid_in = 1'b1;
        w = 0;
        while (!ready_a && w < 40) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        data_in = pack8(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000);
        lat = 1;
        while (!valid_a && lat < 40) begin @(posedge clk); #1; lat++; end
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL bp_latency: got %0d want 9", lat); end
        for (int k = 0; k < 6; k++) begin
            vectors++; if (valid_a !== 1'b1) begin miscompares++; $display("FAIL bp_hold%0d_valid: got %b want 1", k, valid_a); end
            vectors++; if (data_a !== 32'h41080000) begin miscompares++; $display("FAIL bp_hold%0d_data: got %h want 41080000", k, data_a); end
            vectors++; if (last_a !== 1'b0) begin miscompares++; $display("FAIL bp_hold%0d_last: got %b want 0", k, last_a); end
            vectors++; if (ready_a !== 1'b0) begin miscompares++; $display("FAIL bp_hold%0d_ready: got %b want 0", k, ready_a); end
            if (k < 5) begin @(posedge clk); #1; end
        end
        ready_out = 1'b1;
        @(posedge clk); #1;
        vectors++; if (ready_a !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after: got %b want 1", ready_a); end
        vectors++; if (valid_a !== 1'b0) begin miscompares++; $display("FAIL bp_valid_after: got %b want 0", valid_a); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 1;
        while (!valid_a && lat < 40) begin @(posedge clk); #1; lat++; end
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL bp_second_latency: got %0d want 9", lat); end
        vectors++; if (data_a !== 32'h42120000) begin miscompares++; $display("FAIL bp_second_data: got %h want 42120000", data_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_frame();
        logic [31:0] oa, orr; logic la, lr, vr; int lat;
        logic exp_last [6];
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            run_pixel({8{32'h3F800000}}, oa, orr, la, lr, vr, lat);
            vectors++; if (la !== exp_last[k]) begin miscompares++; $display("FAIL frame%0d_last: got %b want %b", k + 1, la, exp_last[k]); end
            vectors++; if (lr !== 1'b1) begin miscompares++; $display("FAIL frame%0d_last_pix1: got %b want 1", k + 1, lr); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] oa, orr; logic la, lr, vr; int lat; int w; int seen;
        do_reset();
        for (int k = 0; k < 3; k++) run_pixel({8{32'h3F800000}}, oa, orr, la, lr, vr, lat);
        data_in = {8{32'hBF800000}};
        valid_in = 1'b1;
        w = 0;
        while (!ready_a && w < 40) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (valid_a) seen++;
            @(posedge clk); #1;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort_no_output: got %0d want 0", seen); end
        run_pixel({8{32'h3F800000}}, oa, orr, la, lr, vr, lat);
        vectors++; if (oa !== 32'h41080000) begin miscompares++; $display("FAIL abort_fresh_data: got %h want 41080000", oa); end
        vectors++; if (la !== 1'b0) begin miscompares++; $display("FAIL abort_fresh_last: got %b want 0", la); end
        for (int k = 0; k < 3; k++) run_pixel({8{32'h3F800000}}, oa, orr, la, lr, vr, lat);
        vectors++; if (la !== 1'b1) begin miscompares++; $display("FAIL abort_fourth_last: got %b want 1", la); end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, val1;
        acc1 = -1; acc2 = -1; val1 = -1;
        ready_out = 1'b1;
        data_in = {8{32'h3F800000}};
        valid_in = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (ready_a) begin
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end
            if (valid_a && val1 < 0) val1 = cyc;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        vectors++; if (acc2 - acc1 !== 10) begin miscompares++; $display("FAIL b2b_spacing: got %0d want 10", acc2 - acc1); end
        vectors++; if (val1 - acc1 !== 9) begin miscompares++; $display("FAIL b2b_latency: got %0d want 9", val1 - acc1); end
        vectors++; if (acc2 - val1 !== 1) begin miscompares++; $display("FAIL b2b_reaccept: got %0d want 1", acc2 - val1); end
        repeat (15) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        ready_out = 1'b1;
        data_in = '0;
        test_reset();
        test_basic();
        test_relu();
        test_cancel_order();
        test_arith_edges();
        test_backpressure();
        test_frame();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
